// File: rtl/wb_dma_master_arb.sv
// Round-robin arbiter sharing the DMA Wishbone master port among NREQ internal
// masters. The grant changes only between wb_cyc cycles. A watchdog aborts a
// strobe that the slave leaves unanswered for TIMEOUT cycles.
module wb_dma_master_arb #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned TW      = 16
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [NREQ-1:0]    m_cyc_i,
    input  logic [NREQ-1:0]    m_stb_i,
    input  logic [NREQ-1:0]    m_we_i,
    input  logic [NREQ-1:0]    m_cab_i,
    input  logic [4*NREQ-1:0]  m_sel_i,
    input  logic [32*NREQ-1:0] m_adr_i,
    input  logic [32*NREQ-1:0] m_dat_i,
    input  logic [32*NREQ-1:0] m_dat64_i,
    output logic [31:0]        m_dat_o,
    output logic [31:0]        m_dat64_o,
    output logic [NREQ-1:0]    m_ack_o,
    output logic [NREQ-1:0]    m_err_o,
    output logic [NREQ-1:0]    m_rty_o,
    output logic [NREQ-1:0]    gnt_o,
    output logic               wb_cyc_o,
    output logic               wb_stb_o,
    output logic               wb_we_o,
    output logic               wb_cab_o,
    output logic [3:0]         wb_sel_o,
    output logic [31:0]        wb_adr_o,
    output logic [31:0]        wb_dat_o,
    output logic [31:0]        wb_dat64_o,
    input  logic [31:0]        wb_dat_i,
    input  logic [31:0]        wb_dat64_i,
    input  logic               wb_ack_i,
    input  logic               wb_err_i,
    input  logic               wb_rty_i,
    output logic               timeout_o,
    input  logic               timeout_clear_i,
    output logic [1:0]         arb_state_o
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StOwn   = 2'd1,
        StAbort = 2'd2,
        StTurn  = 2'd3
    } arb_state_e;

    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_q, last_d;
    logic [TW-1:0]   wd_q, wd_d;
    logic            timeout_q, timeout_d;

    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic            bus_on;
    logic            resp;
    logic            stalled;
    logic            expire;

    // Live bus: owner still holds cyc and we are not aborting.
    assign bus_on  = (state_q == StOwn) && m_cyc_i[owner_q];
    assign resp    = wb_ack_i | wb_err_i | wb_rty_i;
    assign stalled = bus_on && m_stb_i[owner_q] && !resp;
    // An ack in the expiry cycle clears 'stalled', so the ack wins.
    assign expire  = stalled && (wd_q == TW'(TIMEOUT - 1));

    // Round-robin pick: first requester after the last owner.
    always_comb begin
        int unsigned j;
        pick_valid = 1'b0;
        pick_idx   = '0;
        j          = 0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            j = (32'(last_q) + i) % NREQ;
            if (!pick_valid && m_cyc_i[j]) begin
                pick_valid = 1'b1;
                pick_idx   = IW'(j);
            end
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            owner_q   <= '0;
            last_q    <= IW'(NREQ - 1);
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic: arbitration, ownership release, watchdog.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        last_d    = last_q;
        wd_d      = wd_q;
        // A new expiry beats a simultaneous clear.
        timeout_d = expire ? 1'b1 : (timeout_clear_i ? 1'b0 : timeout_q);
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d         = StOwn;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    owner_d         = pick_idx;
                    wd_d            = '0;
                end
            end
            StOwn: begin
                if (!m_cyc_i[owner_q]) begin
                    state_d = StTurn;
                    last_d  = owner_q;
                    gnt_d   = '0;
                end else if (expire) begin
                    state_d = StAbort;
                end else if (resp) begin
                    wd_d = '0;
                end else if (stalled) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            StAbort: begin
                if (!m_cyc_i[owner_q]) begin
                    state_d = StTurn;
                    last_d  = owner_q;
                    gnt_d   = '0;
                end
            end
            StTurn: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: owner's signals onto the bus, slave responses back to the owner.
    always_comb begin
        wb_cyc_o    = bus_on;
        wb_stb_o    = bus_on && m_stb_i[owner_q];
        wb_we_o     = bus_on && m_we_i[owner_q];
        wb_cab_o    = bus_on && m_cab_i[owner_q];
        wb_sel_o    = bus_on ? m_sel_i[owner_q*4 +: 4] : 4'd0;
        wb_adr_o    = bus_on ? m_adr_i[owner_q*32 +: 32] : 32'd0;
        wb_dat_o    = bus_on ? m_dat_i[owner_q*32 +: 32] : 32'd0;
        wb_dat64_o  = bus_on ? m_dat64_i[owner_q*32 +: 32] : 32'd0;
        m_ack_o     = bus_on ? (gnt_q & {NREQ{wb_ack_i}}) : '0;
        m_err_o     = bus_on ? (gnt_q & {NREQ{wb_err_i | expire}}) : '0;
        m_rty_o     = bus_on ? (gnt_q & {NREQ{wb_rty_i}}) : '0;
        m_dat_o     = wb_dat_i;
        m_dat64_o   = wb_dat64_i;
        gnt_o       = gnt_q;
        timeout_o   = timeout_q;
        arb_state_o = state_q;
    end

endmodule

// File: tb/tb_wb_dma_master_arb.sv
// Self-checking bench for wb_dma_master_arb: directed vector table, hand-written
// corner sequences, and randomized traffic against a behavioural model.
module tb_wb_dma_master_arb;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;
    localparam int TW      = 16;

    logic                 wb_clk_i = 1'b0;
    logic                 wb_rst_i;
    logic [NREQ-1:0]      m_cyc_i, m_stb_i, m_we_i, m_cab_i;
    logic [4*NREQ-1:0]    m_sel_i;
    logic [32*NREQ-1:0]   m_adr_i, m_dat_i, m_dat64_i;
    logic [31:0]          m_dat_o, m_dat64_o;
    logic [NREQ-1:0]      m_ack_o, m_err_o, m_rty_o, gnt_o;
    logic                 wb_cyc_o, wb_stb_o, wb_we_o, wb_cab_o;
    logic [3:0]           wb_sel_o;
    logic [31:0]          wb_adr_o, wb_dat_o, wb_dat64_o;
    logic [31:0]          wb_dat_i, wb_dat64_i;
    logic                 wb_ack_i, wb_err_i, wb_rty_i;
    logic                 timeout_o, timeout_clear_i;
    logic [1:0]           arb_state_o;

    wb_dma_master_arb #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_cab_i(m_cab_i),
        .m_sel_i(m_sel_i), .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat64_i(m_dat64_i),
        .m_dat_o(m_dat_o), .m_dat64_o(m_dat64_o),
        .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o), .gnt_o(gnt_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_cab_o(wb_cab_o),
        .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
        .wb_dat64_o(wb_dat64_o), .wb_dat_i(wb_dat_i), .wb_dat64_i(wb_dat64_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
        .timeout_o(timeout_o), .timeout_clear_i(timeout_clear_i),
        .arb_state_o(arb_state_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the bus, whether it was aborted, whether a
    // turnaround cycle is pending, stall length, last owner, sticky flag.
    int mo_owner;
    bit mo_abort;
    bit mo_turn;
    int mo_stall;
    int mo_last;
    bit mo_tflag;

    task automatic model_reset();
        mo_owner = -1;
        mo_abort = 0;
        mo_turn  = 0;
        mo_stall = 0;
        mo_last  = NREQ - 1;
        mo_tflag = 0;
    endtask

    function automatic bit mo_bus();
        return (mo_owner >= 0) && !mo_abort && (m_cyc_i[mo_owner] == 1'b1);
    endfunction

    function automatic bit mo_resp();
        return (wb_ack_i | wb_err_i | wb_rty_i) == 1'b1;
    endfunction

    function automatic bit mo_expire();
        return mo_bus() && (m_stb_i[mo_owner] == 1'b1) && !mo_resp()
               && (mo_stall == TIMEOUT - 1);
    endfunction

    task automatic model_check();
        bit              b;
        int              o;
        logic [NREQ-1:0] one;
        logic [1:0]      st;
        b   = mo_bus();
        o   = (mo_owner < 0) ? 0 : mo_owner;
        one = '0;
        if (mo_owner >= 0) one[mo_owner] = 1'b1;
        st  = (mo_owner >= 0) ? (mo_abort ? 2'd2 : 2'd1) : (mo_turn ? 2'd3 : 2'd0);
        chk("gnt", gnt_o, one);
        chk("state", arb_state_o, st);
        chk("wb_cyc", wb_cyc_o, b);
        chk("wb_stb", wb_stb_o, b & m_stb_i[o]);
        chk("wb_ctl", {wb_we_o, wb_cab_o, wb_sel_o},
            b ? {m_we_i[o], m_cab_i[o], m_sel_i[4*o +: 4]} : 6'd0);
        chk("wb_adr", wb_adr_o, b ? m_adr_i[32*o +: 32] : 32'd0);
        chk("wb_dat", {wb_dat64_o, wb_dat_o},
            b ? {m_dat64_i[32*o +: 32], m_dat_i[32*o +: 32]} : 64'd0);
        chk("m_ack", m_ack_o, (b && wb_ack_i) ? one : '0);
        chk("m_err", m_err_o, (b && (wb_err_i || mo_expire())) ? one : '0);
        chk("m_rty", m_rty_o, (b && wb_rty_i) ? one : '0);
        chk("timeout", timeout_o, mo_tflag);
        chk("m_dat", {m_dat64_o, m_dat_o}, {wb_dat64_i, wb_dat_i});
    endtask

    task automatic model_update();
        bit ex, rs, b;
        if (wb_rst_i) begin
            model_reset();
            return;
        end
        ex = mo_expire();
        rs = mo_resp();
        b  = mo_bus();
        if (ex) mo_tflag = 1;
        else if (timeout_clear_i) mo_tflag = 0;
        if (mo_owner < 0) begin
            if (mo_turn) mo_turn = 0;
            else if (m_cyc_i != 0) begin
                for (int i = 1; i <= NREQ; i++) begin
                    int c = (mo_last + i) % NREQ;
                    if (m_cyc_i[c]) begin
                        mo_owner = c;
                        break;
                    end
                end
                mo_stall = 0;
            end
        end else if (!m_cyc_i[mo_owner]) begin
            mo_last  = mo_owner;
            mo_owner = -1;
            mo_abort = 0;
            mo_turn  = 1;
        end else if (!mo_abort) begin
            if (ex) mo_abort = 1;
            else if (rs) mo_stall = 0;
            else if (b && m_stb_i[mo_owner]) mo_stall++;
        end
    endtask

    // Inputs are set just after a falling edge; check, clock, advance model.
    task automatic tick();
        #2;
        model_check();
        @(posedge wb_clk_i);
        model_update();
        @(negedge wb_clk_i);
    endtask

    task automatic idle_inputs();
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; m_cab_i = '0;
        wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0; timeout_clear_i = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        wb_rst_i = 1;
        model_reset();
        tick();
        wb_rst_i = 0;
    endtask

    typedef struct {
        bit         rst;
        logic [3:0] cyc;
        bit         ack;
        logic [3:0] gnt;
        bit         wcyc;
        logic [1:0] st;
        logic [3:0] mack;
        logic [31:0] adr;
    } vec_t;

    vec_t tbl[29];

    initial begin
        int acks[NREQ];
        int order[$];
        bit quiet;
        int r;

        wb_rst_i = 1;
        idle_inputs();
        m_sel_i = 16'h8421;
        wb_dat_i = 32'h1234_5678;
        wb_dat64_i = 32'h9abc_def0;
        for (int k = 0; k < NREQ; k++) begin
            m_adr_i[32*k +: 32]   = 32'hA000_0000 | (k << 4);
            m_dat_i[32*k +: 32]   = 32'hD000_0000 + k;
            m_dat64_i[32*k +: 32] = 32'hE000_0000 + k;
        end
        model_reset();

        // rst, cyc(=stb=cab), ack -> gnt, wb_cyc, state, m_ack, wb_adr
        tbl[0]  = '{1, 4'b0000, 0, 4'b0000, 0, 2'd0, 4'b0000, 32'h0};
        tbl[1]  = '{0, 4'b0000, 0, 4'b0000, 0, 2'd0, 4'b0000, 32'h0};
        tbl[2]  = '{0, 4'b0010, 0, 4'b0000, 0, 2'd0, 4'b0000, 32'h0};
        tbl[3]  = '{0, 4'b0010, 0, 4'b0010, 1, 2'd1, 4'b0000, 32'hA000_0010};
        tbl[4]  = '{0, 4'b0010, 1, 4'b0010, 1, 2'd1, 4'b0010, 32'hA000_0010};
        tbl[5]  = '{0, 4'b0011, 1, 4'b0010, 1, 2'd1, 4'b0010, 32'hA000_0010};
        tbl[6]  = '{0, 4'b0001, 0, 4'b0010, 0, 2'd1, 4'b0000, 32'h0};
        tbl[7]  = '{0, 4'b0001, 0, 4'b0000, 0, 2'd3, 4'b0000, 32'h0};
        tbl[8]  = '{0, 4'b0001, 0, 4'b0000, 0, 2'd0, 4'b0000, 32'h0};
        tbl[9]  = '{0, 4'b0001, 1, 4'b0001, 1, 2'd1, 4'b0001, 32'hA000_0000};
        tbl[10] = '{0, 4'b0101, 1, 4'b0001, 1, 2'd1, 4'b0001, 32'hA000_0000};
        tbl[11] = '{0, 4'b0100, 0, 4'b0001, 0, 2'd1, 4'b0000, 32'h0};
        tbl[12] = '{0, 4'b0100, 0, 4'b0000, 0, 2'd3, 4'b0000, 32'h0};
        tbl[13] = '{0, 4'b0100, 0, 4'b0000, 0, 2'd0, 4'b0000, 32'h0};
        tbl[14] = '{0, 4'b0100, 1, 4'b0100, 1, 2'd1, 4'b0100, 32'hA000_0020};
        tbl[15] = '{0, 4'b0101, 1, 4'b0100, 1, 2'd1, 4'b0100, 32'hA000_0020};
        tbl[16] = '{0, 4'b1101, 1, 4'b0100, 1, 2'd1, 4'b0100, 32'hA000_0020};
        tbl[17] = '{0, 4'b1101, 1, 4'b0100, 1, 2'd1, 4'b0100, 32'hA000_0020};
        tbl[18] = '{0, 4'b1001, 0, 4'b0100, 0, 2'd1, 4'b0000, 32'h0};
        tbl[19] = '{0, 4'b1001, 0, 4'b0000, 0, 2'd3, 4'b0000, 32'h0};
        tbl[20] = '{0, 4'b1001, 0, 4'b0000, 0, 2'd0, 4'b0000, 32'h0};
        tbl[21] = '{0, 4'b1001, 0, 4'b1000, 1, 2'd1, 4'b0000, 32'hA000_0030};
        tbl[22] = '{0, 4'b0001, 0, 4'b1000, 0, 2'd1, 4'b0000, 32'h0};
        tbl[23] = '{0, 4'b0001, 0, 4'b0000, 0, 2'd3, 4'b0000, 32'h0};
        tbl[24] = '{0, 4'b0001, 0, 4'b0000, 0, 2'd0, 4'b0000, 32'h0};
        tbl[25] = '{0, 4'b0001, 0, 4'b0001, 1, 2'd1, 4'b0000, 32'hA000_0000};
        tbl[26] = '{0, 4'b0000, 0, 4'b0001, 0, 2'd1, 4'b0000, 32'h0};
        tbl[27] = '{0, 4'b0000, 0, 4'b0000, 0, 2'd3, 4'b0000, 32'h0};
        tbl[28] = '{0, 4'b0000, 0, 4'b0000, 0, 2'd0, 4'b0000, 32'h0};

        @(negedge wb_clk_i);
        foreach (tbl[i]) begin
            wb_rst_i = tbl[i].rst;
            m_cyc_i  = tbl[i].cyc;
            m_stb_i  = tbl[i].cyc;
            m_cab_i  = tbl[i].cyc;
            wb_ack_i = tbl[i].ack;
            #1;
            chk("tbl_gnt", gnt_o, tbl[i].gnt);
            chk("tbl_wb_cyc", wb_cyc_o, tbl[i].wcyc);
            chk("tbl_state", arb_state_o, tbl[i].st);
            chk("tbl_m_ack", m_ack_o, tbl[i].mack);
            chk("tbl_wb_adr", wb_adr_o, tbl[i].adr);
            tick();
        end

        // All four request at once; each drops after two acks.
        do_reset();
        foreach (acks[k]) acks[k] = 0;
        m_cyc_i = 4'hF; m_stb_i = 4'hF; wb_ack_i = 1;
        for (int c = 0; c < 80 && m_cyc_i != 0; c++) begin
            #1;
            for (int k = 0; k < NREQ; k++) begin
                if (m_ack_o[k]) acks[k]++;
                if (gnt_o[k] && (order.size() == 0 || order[$] != k)) order.push_back(k);
            end
            tick();
            for (int k = 0; k < NREQ; k++) if (acks[k] >= 2) m_cyc_i[k] = 1'b0;
            m_stb_i = m_cyc_i;
        end
        chk("rr_owner_count", order.size(), NREQ);
        for (int i = 0; i < NREQ; i++) begin
            chk("rr_order", (i < order.size()) ? order[i] : -1, i);
            chk("rr_acks", acks[i], 2);
        end

        // Watchdog expiry with a silent slave.
        do_reset();
        m_cyc_i = 4'b0001; m_stb_i = 4'b0001;
        tick();
        for (int k = 1; k <= TIMEOUT; k++) begin
            #1;
            chk("wd_err_pulse", m_err_o, (k == TIMEOUT) ? 4'b0001 : 4'b0000);
            tick();
        end
        #1;
        chk("wd_cyc_dropped", wb_cyc_o, 1'b0);
        chk("wd_abort_state", arb_state_o, 2'd2);
        chk("wd_flag", timeout_o, 1'b1);
        chk("wd_gnt_held", gnt_o, 4'b0001);
        tick();
        tick();
        m_cyc_i = 0; m_stb_i = 0;
        #1;
        chk("wd_abort_until_drop", arb_state_o, 2'd2);
        tick();
        #1;
        chk("wd_turn", arb_state_o, 2'd3);
        tick();
        timeout_clear_i = 1;
        tick();
        timeout_clear_i = 0;
        #1;
        chk("wd_flag_cleared", timeout_o, 1'b0);

        // Ack lands on the would-be expiry cycle.
        do_reset();
        m_cyc_i = 4'b0010; m_stb_i = 4'b0010;
        tick();
        for (int k = 1; k < TIMEOUT; k++) tick();
        wb_ack_i = 1;
        #1;
        chk("ack_wins_err", m_err_o, 4'b0000);
        chk("ack_wins_ack", m_ack_o, 4'b0010);
        tick();
        wb_ack_i = 0;
        #1;
        chk("ack_wins_state", arb_state_o, 2'd1);
        chk("ack_wins_flag", timeout_o, 1'b0);
        tick();
        m_cyc_i = 0; m_stb_i = 0;
        tick(); tick(); tick();

        // Asynchronous reset in the middle of an acked burst.
        do_reset();
        m_cyc_i = 4'b0100; m_stb_i = 4'b0100; m_cab_i = 4'b0100; wb_ack_i = 1;
        tick();
        tick();
        #1;
        wb_rst_i = 1;
        model_reset();
        #1;
        chk("rst_gnt", gnt_o, 4'b0000);
        chk("rst_wb_cyc", wb_cyc_o, 1'b0);
        chk("rst_m_ack", m_ack_o, 4'b0000);
        chk("rst_state", arb_state_o, 2'd0);
        tick();
        wb_rst_i = 0;
        m_cyc_i = 4'hF; m_stb_i = 4'hF; m_cab_i = 0;
        tick();
        #1;
        chk("rst_pointer", gnt_o, 4'b0001);
        idle_inputs();
        tick(); tick(); tick();

        // Randomized traffic against the model.
        do_reset();
        quiet = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 80 == 0) quiet = ($urandom_range(0, 2) == 0);
            for (int k = 0; k < NREQ; k++)
                if ($urandom_range(0, 29) == 0) m_cyc_i[k] = ~m_cyc_i[k];
            m_stb_i = m_cyc_i & (4'($urandom) | 4'($urandom));
            m_we_i  = 4'($urandom);
            m_cab_i = 4'($urandom);
            m_sel_i = 16'($urandom);
            for (int k = 0; k < NREQ; k++) begin
                m_adr_i[32*k +: 32]   = $urandom;
                m_dat_i[32*k +: 32]   = $urandom;
                m_dat64_i[32*k +: 32] = $urandom;
            end
            r = $urandom_range(0, 7);
            wb_ack_i = !quiet && (r < 3);
            wb_err_i = !quiet && (r == 3);
            wb_rty_i = !quiet && (r == 4);
            wb_dat_i   = $urandom;
            wb_dat64_i = $urandom;
            timeout_clear_i = ($urandom_range(0, 15) == 0);
            wb_rst_i = ($urandom_range(0, 499) == 0);
            if (wb_rst_i) model_reset();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
